// File: rtl/debug_ctrl.sv
// Debug controller: arbitrates the datapath control word between the sequencer and
// an external debugger, with breakpoints, single-step and a sticky halt flag.
module debug_ctrl #(
    parameter int            CW         = 20,
    parameter int            AW         = 4,
    parameter int            NBP        = 2,
    parameter int            HLT_BIT    = 1,
    parameter logic [CW-1:0] FORCE_MASK = {CW{1'b0}},
    parameter logic [CW-1:0] FORCE_VAL  = {CW{1'b1}}
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            T0,
    input  logic [AW-1:0]   PC,
    input  logic [CW-1:0]   C_CTRL,
    input  logic [CW-1:0]   D_CTRL,
    input  logic            DEBUG_REQUEST,
    input  logic            STEP,
    input  logic            BP_WE,
    input  logic [2:0]      BP_IDX,
    input  logic [AW-1:0]   BP_ADDR,
    input  logic            BP_EN,
    output logic [CW-1:0]   CTRL,
    output logic            RUN,
    output logic            DEBUG_ACK,
    output logic            HALTED,
    output logic [NBP-1:0]  BP_HIT,
    output logic [1:0]      STATE
);

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        DEBUG    = 2'd1,
        STEPPING = 2'd2
    } state_t;

    state_t                  state;
    logic [NBP-1:0][AW-1:0]  bp_addr;
    logic [NBP-1:0]          bp_en;
    logic [NBP-1:0]          match;
    logic                    skip;
    logic                    step_armed;

    always_comb begin
        match = '0;
        for (int i = 0; i < NBP; i++) begin
            match[i] = bp_en[i] & (bp_addr[i] == PC) & ~skip;
        end
    end

    // While reset is held the sequencer path is selected and the core keeps running.
    assign CTRL  = (RESETn && state == DEBUG) ? D_CTRL
                                              : ((C_CTRL & ~FORCE_MASK) | (FORCE_VAL & FORCE_MASK));
    assign RUN   = ~RESETn | ((state != DEBUG) & ~HALTED);
    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state      <= RUNNING;
            DEBUG_ACK  <= 1'b0;
            HALTED     <= 1'b0;
            BP_HIT     <= '0;
            skip       <= 1'b0;
            step_armed <= 1'b0;
            bp_addr    <= '0;
            bp_en      <= '0;
        end else begin
            if (CTRL[HLT_BIT]) begin
                HALTED <= 1'b1;
            end
            // A set from a DEBUG exit below overrides this clear in the same cycle.
            if (!T0) begin
                skip <= 1'b0;
            end
            if (state == STEPPING && !T0) begin
                step_armed <= 1'b1;
            end
            for (int i = 0; i < NBP; i++) begin
                if (BP_WE && BP_IDX == 3'(i)) begin
                    bp_addr[i] <= BP_ADDR;
                    bp_en[i]   <= BP_EN;
                end
            end

            case (state)
                RUNNING: begin
                    if ((T0 && (DEBUG_REQUEST || (|match))) || (HALTED && DEBUG_REQUEST)) begin
                        state     <= DEBUG;
                        DEBUG_ACK <= 1'b1;
                        BP_HIT    <= match;
                    end
                end
                DEBUG: begin
                    if (!DEBUG_REQUEST) begin
                        state     <= RUNNING;
                        DEBUG_ACK <= 1'b0;
                        BP_HIT    <= '0;
                        skip      <= 1'b1;
                    end else if (STEP) begin
                        state      <= STEPPING;
                        DEBUG_ACK  <= 1'b0;
                        BP_HIT     <= '0;
                        skip       <= 1'b1;
                        step_armed <= 1'b0;
                    end
                end
                STEPPING: begin
                    if ((T0 && step_armed) || HALTED) begin
                        state     <= DEBUG;
                        DEBUG_ACK <= 1'b1;
                        BP_HIT    <= '0;
                    end
                end
                default: begin
                    state     <= RUNNING;
                    DEBUG_ACK <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the debug protocol.
module tb_debug_ctrl;

    localparam int            CW    = 20;
    localparam int            AW    = 4;
    localparam int            NBP   = 2;
    localparam int            HLT   = 1;
    localparam logic [CW-1:0] FMASK = 20'h80000;
    localparam logic [CW-1:0] FVAL  = {CW{1'b1}};
    localparam logic [CW-1:0] DBG_WORD = 20'h0A5A0;

    logic            CLK = 1'b0;
    logic            RESETn, T0, DEBUG_REQUEST, STEP, BP_WE, BP_EN;
    logic [AW-1:0]   PC, BP_ADDR;
    logic [CW-1:0]   C_CTRL, D_CTRL;
    logic [2:0]      BP_IDX;
    logic [CW-1:0]   CTRL;
    logic            RUN, DEBUG_ACK, HALTED;
    logic [NBP-1:0]  BP_HIT;
    logic [1:0]      STATE;

    int testCount = 0;
    int failCount = 0;

    // Reference model: mode 0 = running, 1 = in debug, 2 = stepping
    int              mMode;
    bit              mHalted, mSkip, mArmed;
    bit [NBP-1:0]    mHit;
    bit [AW-1:0]     bpAddr [8];
    bit              bpEn   [8];

    always #5 CLK = ~CLK;

    debug_ctrl #(
        .CW(CW), .AW(AW), .NBP(NBP), .HLT_BIT(HLT),
        .FORCE_MASK(FMASK), .FORCE_VAL(FVAL)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .T0(T0), .PC(PC),
        .C_CTRL(C_CTRL), .D_CTRL(D_CTRL),
        .DEBUG_REQUEST(DEBUG_REQUEST), .STEP(STEP),
        .BP_WE(BP_WE), .BP_IDX(BP_IDX), .BP_ADDR(BP_ADDR), .BP_EN(BP_EN),
        .CTRL(CTRL), .RUN(RUN), .DEBUG_ACK(DEBUG_ACK), .HALTED(HALTED),
        .BP_HIT(BP_HIT), .STATE(STATE)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [CW-1:0] modelCtrl();
        if (RESETn && mMode == 1) return D_CTRL;
        return (C_CTRL & ~FMASK) | (FVAL & FMASK);
    endfunction

    task automatic modelReset();
        mMode = 0; mHalted = 0; mSkip = 0; mArmed = 0; mHit = '0;
        for (int i = 0; i < 8; i++) begin
            bpAddr[i] = '0;
            bpEn[i]   = 0;
        end
    endtask

    task automatic modelStep();
        bit [NBP-1:0]  hits;
        bit [CW-1:0]   ctrlNow;
        int            nextMode;
        bit            leftDebug;
        if (!RESETn) begin
            modelReset();
            return;
        end
        hits = '0;
        for (int i = 0; i < NBP; i++)
            if (bpEn[i] && bpAddr[i] == PC && !mSkip) hits[i] = 1;
        ctrlNow   = modelCtrl();
        nextMode  = mMode;
        leftDebug = 0;
        if (mMode == 0) begin
            if ((T0 && (DEBUG_REQUEST || hits != 0)) || (mHalted && DEBUG_REQUEST)) begin
                nextMode = 1;
                mHit     = hits;
            end
        end else if (mMode == 1) begin
            if (!DEBUG_REQUEST) nextMode = 0;
            else if (STEP)      nextMode = 2;
            if (nextMode != 1) begin
                mHit      = '0;
                leftDebug = 1;
            end
        end else begin
            if ((T0 && mArmed) || mHalted) begin
                nextMode = 1;
                mHit     = '0;
            end
        end
        if (mMode == 2 && !T0) mArmed = 1;
        if (mMode == 1 && nextMode == 2) mArmed = 0;
        if (!T0) mSkip = 0;
        if (leftDebug) mSkip = 1;
        if (ctrlNow[HLT]) mHalted = 1;
        if (BP_WE && int'(BP_IDX) < NBP) begin
            bpAddr[BP_IDX] = BP_ADDR;
            bpEn[BP_IDX]   = BP_EN;
        end
        mMode = nextMode;
    endtask

    // Inputs are already set at the falling edge; check, advance the model, then cross the rising edge.
    task automatic applyStimulus();
        #1;
        checkOutput("state",   32'(STATE),     32'(mMode));
        checkOutput("ack",     32'(DEBUG_ACK), 32'(mMode == 1));
        checkOutput("halted",  32'(HALTED),    32'(mHalted));
        checkOutput("bp_hit",  32'(BP_HIT),    32'(mHit));
        checkOutput("run",     32'(RUN),       32'(!RESETn || (mMode != 1 && !mHalted)));
        checkOutput("ctrl",    32'(CTRL),      32'(modelCtrl()));
        modelStep();
        @(negedge CLK);
    endtask

    task automatic setIdle();
        RESETn = 1; T0 = 0; PC = '0; C_CTRL = '0; D_CTRL = DBG_WORD;
        DEBUG_REQUEST = 0; STEP = 0; BP_WE = 0; BP_IDX = '0; BP_ADDR = '0; BP_EN = 0;
    endtask

    task automatic doReset();
        setIdle();
        RESETn = 0;
        applyStimulus();
        RESETn = 1;
    endtask

    initial begin
        modelReset();
        setIdle();
        RESETn = 0;
        @(negedge CLK);

        // Reset values
        applyStimulus();
        checkOutput("rst_state", 32'(STATE), 32'd0);
        checkOutput("rst_ack",   32'(DEBUG_ACK), 32'd0);
        checkOutput("rst_halt",  32'(HALTED), 32'd0);
        checkOutput("rst_hit",   32'(BP_HIT), 32'd0);
        checkOutput("rst_run",   32'(RUN), 32'd1);
        RESETn = 1;

        // Request entry waits for an instruction boundary
        DEBUG_REQUEST = 1; T0 = 0;
        applyStimulus();
        checkOutput("req_wait_state", 32'(STATE), 32'd0);
        T0 = 1;
        applyStimulus();
        checkOutput("req_ack",  32'(DEBUG_ACK), 32'd1);
        checkOutput("req_ctrl", 32'(CTRL), 32'(DBG_WORD));
        checkOutput("req_run",  32'(RUN), 32'd0);

        // Breakpoint entry and resume without re-trigger
        doReset();
        BP_WE = 1; BP_IDX = 3'd0; BP_ADDR = 4'd5; BP_EN = 1;
        applyStimulus();
        BP_WE = 0; PC = 4'd5; T0 = 1;
        applyStimulus();
        checkOutput("bp_state", 32'(STATE), 32'd1);
        checkOutput("bp_hit01", 32'(BP_HIT), 32'd1);
        DEBUG_REQUEST = 1;
        applyStimulus();
        DEBUG_REQUEST = 0;
        applyStimulus();
        checkOutput("resume_state", 32'(STATE), 32'd0);
        checkOutput("resume_hit",   32'(BP_HIT), 32'd0);
        repeat (3) applyStimulus();
        checkOutput("no_retrigger", 32'(STATE), 32'd0);
        T0 = 0; PC = 4'd6;
        applyStimulus();
        T0 = 1; PC = 4'd5;
        applyStimulus();
        checkOutput("reentry_state", 32'(STATE), 32'd1);
        checkOutput("reentry_hit",   32'(BP_HIT), 32'd1);

        // Single step
        DEBUG_REQUEST = 1; STEP = 1; T0 = 1;
        applyStimulus();
        checkOutput("step_state", 32'(STATE), 32'd2);
        STEP = 0; T0 = 0;
        repeat (3) applyStimulus();
        checkOutput("step_hold", 32'(STATE), 32'd2);
        T0 = 1;
        applyStimulus();
        checkOutput("step_done_state", 32'(STATE), 32'd1);
        checkOutput("step_done_hit",   32'(BP_HIT), 32'd0);

        // Reset mid-step with a coincident breakpoint write
        STEP = 1;
        applyStimulus();
        checkOutput("step2_state", 32'(STATE), 32'd2);
        STEP = 0; RESETn = 0; BP_WE = 1; BP_IDX = 3'd1; BP_ADDR = 4'd5; BP_EN = 1;
        applyStimulus();
        checkOutput("midstep_rst_state", 32'(STATE), 32'd0);
        checkOutput("midstep_rst_halt",  32'(HALTED), 32'd0);
        RESETn = 1; BP_WE = 0; DEBUG_REQUEST = 0; PC = 4'd5; T0 = 1;
        applyStimulus();
        checkOutput("bp_cleared", 32'(STATE), 32'd0);

        // Dropped request beats STEP
        DEBUG_REQUEST = 1;
        applyStimulus();
        DEBUG_REQUEST = 0; STEP = 1;
        applyStimulus();
        checkOutput("drop_beats_step", 32'(STATE), 32'd0);
        STEP = 0;

        // Out-of-range breakpoint index is ignored
        BP_WE = 1; BP_IDX = 3'd7; BP_ADDR = 4'd5; BP_EN = 1; T0 = 0;
        applyStimulus();
        BP_WE = 0; PC = 4'd5; T0 = 1;
        applyStimulus();
        checkOutput("idx7_ignored", 32'(STATE), 32'd0);

        // Forced bits and sticky halt
        doReset();
        C_CTRL = '0;
        applyStimulus();
        checkOutput("force_bit19", 32'(CTRL), 32'h80000);
        C_CTRL = 20'h00002;
        applyStimulus();
        checkOutput("halt_set", 32'(HALTED), 32'd1);
        checkOutput("halt_run", 32'(RUN), 32'd0);
        C_CTRL = '0; DEBUG_REQUEST = 1; T0 = 0;
        applyStimulus();
        checkOutput("halt_entry", 32'(STATE), 32'd1);

        // Random traffic
        doReset();
        for (int n = 0; n < 3000; n++) begin
            RESETn = ($urandom_range(0, 99) != 0);
            T0     = 1'($urandom_range(0, 1));
            PC     = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) DEBUG_REQUEST = ~DEBUG_REQUEST;
            STEP   = ($urandom_range(0, 3) == 0);
            BP_WE  = ($urandom_range(0, 7) == 0);
            BP_IDX = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            BP_ADDR = AW'($urandom_range(0, 3));
            BP_EN  = ($urandom_range(0, 3) != 0);
            C_CTRL = CW'($urandom) & ~20'h00002;
            D_CTRL = CW'($urandom) & ~20'h00002;
            if ($urandom_range(0, 299) == 0) C_CTRL[HLT] = 1'b1;
            if ($urandom_range(0, 299) == 0) D_CTRL[HLT] = 1'b1;
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter CW, 20: control-word width.
REQ-002 Parameter AW, 4: program-counter width.
REQ-003 Parameter NBP, 2: breakpoint count, 1..8.
REQ-004 Parameter HLT_BIT, 1: index of the halt bit in the control word.
REQ-005 Parameter FORCE_MASK, {CW{1'b0}}: bits forced to FORCE_VAL outside DEBUG.
REQ-006 Parameter FORCE_VAL, {CW{1'b1}}: forced values for FORCE_MASK bits.
REQ-007 CLK  in  1  single clock; all state updates on the rising edge.
REQ-008 RESETn  in  1  synchronous, active-low reset.
REQ-009 T0  in  1  sequencer at an instruction boundary.
REQ-010 PC  in  AW  current program counter.
REQ-011 C_CTRL  in  CW  sequencer control word.
REQ-012 D_CTRL  in  CW  debugger control word.
REQ-013 DEBUG_REQUEST  in  1  level request for debug mode.
REQ-014 STEP  in  1  single-instruction step request, sampled in DEBUG only.
REQ-015 BP_WE, BP_IDX[2:0], BP_ADDR[AW-1:0], BP_EN  in  breakpoint write port.
REQ-016 CTRL  out  CW  muxed control word to the datapath.
REQ-017 RUN  out  1  sequencer enable.
REQ-018 DEBUG_ACK  out  1  high while in DEBUG.
REQ-019 HALTED  out  1  sticky halt flag.
REQ-020 BP_HIT  out  NBP  breakpoints that caused the current DEBUG entry.
REQ-021 STATE  out  2  RUNNING=0, DEBUG=1, STEPPING=2.

Function
REQ-022 The FSM states SHALL be RUNNING, DEBUG and STEPPING.
REQ-023 Match i SHALL be bp_en[i] & (bp_addr[i]==PC) & ~skip.
REQ-024 RUNNING->DEBUG SHALL occur when (T0 & (DEBUG_REQUEST | any match)) | (HALTED & DEBUG_REQUEST).
REQ-025 On a RUNNING->DEBUG transition, BP_HIT SHALL load the match vector.
REQ-026 DEBUG->RUNNING SHALL occur when DEBUG_REQUEST=0, taking priority over STEP.
REQ-027 DEBUG->STEPPING SHALL occur when DEBUG_REQUEST=1 & STEP=1.
REQ-028 Every exit from DEBUG SHALL clear BP_HIT and set skip.
REQ-029 skip SHALL clear on the first cycle T0=0 is sampled, so a resumed breakpoint does not re-trigger before its instruction executes.
REQ-030 step_armed SHALL set when T0=0 is sampled in STEPPING and SHALL clear on entry to STEPPING.
REQ-031 STEPPING->DEBUG SHALL occur when (T0 & step_armed) | HALTED, with BP_HIT loaded as 0.
REQ-032 Breakpoint matching SHALL NOT apply in STEPPING.
REQ-033 CTRL SHALL equal D_CTRL in DEBUG.
REQ-034 Outside DEBUG, CTRL SHALL equal C_CTRL with FORCE_MASK bits replaced by FORCE_VAL.
REQ-035 RUN SHALL be (STATE!=DEBUG) & ~HALTED.
REQ-036 DEBUG_ACK SHALL be (STATE==DEBUG), registered, so it rises one edge after the entry condition is sampled.
REQ-037 HALTED SHALL set at the edge where CTRL[HLT_BIT]=1, in any state, and SHALL clear only on reset.
REQ-038 A BP_WE write with BP_IDX<NBP SHALL update bp_addr/bp_en at that edge, and the new value SHALL be used for matching from the next cycle.
REQ-039 A BP_WE write with BP_IDX>=NBP SHALL be ignored.
REQ-040 BP_WE writes SHALL be accepted in every state.

Reset
REQ-041 With RESETn=0 at an edge, the block SHALL set STATE=RUNNING, DEBUG_ACK=0, HALTED=0, BP_HIT=0, skip=0, step_armed=0, and all bp_en=0; bp_addr SHALL be 0.
REQ-042 Reset SHALL override every other event in the same cycle, including mid-STEPPING and a coincident BP_WE.
REQ-043 During reset, RUN SHALL be 1 and CTRL SHALL follow the RUNNING mux.

Verification
REQ-044 Request entry: DEBUG_REQUEST=1 with T0=0 -> STATE stays 0; raise T0 -> DEBUG_ACK=1 next edge, CTRL=D_CTRL, RUN=0.
REQ-045 Breakpoint resume: bp0=(PC 5, en), PC=5, T0=1 -> DEBUG, BP_HIT=2'b01; drop request -> RUNNING, no re-entry while PC=5 and T0=1; after T0 drops, return to PC=5 -> re-enters DEBUG.
REQ-046 Single step: STEP in DEBUG -> STATE=2 with T0 still high; T0 low 3 cycles then high -> STATE=1, BP_HIT=0.
REQ-047 Halt and force: C_CTRL[1]=1 in RUNNING -> HALTED=1, RUN=0; DEBUG_REQUEST=1 with T0=0 -> DEBUG. FORCE_MASK=bit19, C_CTRL=0 -> CTRL[19]=1 outside DEBUG.
REQ-048 Boundaries: BP_WE with BP_IDX=7, NBP=2 -> no match change; DEBUG_REQUEST=0 with STEP=1 -> RUNNING; reset mid-STEPPING -> STATE=0, HALTED=0, all breakpoints disabled.
